param_register_file: RTL

- Parametrised successor to the fixed 8-bit enable/reset register: a bank of NUM_REGS registers, each WIDTH bits wide.
- One write port with per-byte lane enables and a global enable. Two asynchronous read ports.
- Used as the general-purpose register file of the 3-stage processor. Decode reads operands; writeback writes results.

---
 rtl/param_register_file_if.sv | 27 ++
 rtl/param_register_file.sv | 92 +++++++++
 2 files changed

// File: rtl/param_register_file_if.sv
// Register-file access bus: one byte-lane-masked write port and two
// combinational read ports. The master drives addresses, data and controls;
// the slave (the register file) returns read data.
interface param_register_file_if #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 3
);
    logic                  en;
    logic                  we;
    logic [ADDR_W-1:0]     waddr;
    logic [WIDTH-1:0]      wdata;
    logic [WIDTH/8-1:0]    wbe;
    logic [ADDR_W-1:0]     raddr_a;
    logic [WIDTH-1:0]      rdata_a;
    logic [ADDR_W-1:0]     raddr_b;
    logic [WIDTH-1:0]      rdata_b;

    modport master (
        output en, we, waddr, wdata, wbe, raddr_a, raddr_b,
        input  rdata_a, rdata_b
    );

    modport slave (
        input  en, we, waddr, wdata, wbe, raddr_a, raddr_b,
        output rdata_a, rdata_b
    );
endinterface

// File: rtl/param_register_file.sv
// param_register_file: NUM_REGS = 2**ADDR_W registers of WIDTH bits, built
// from flip-flops. One write port with per-byte lane enables gated by a
// global enable, two combinational read ports. Optional register 0
// hardwired to zero (ZERO_REG=1).
// Optional feature: define REGFILE_BYPASS_EN to forward the merged write
// value to a read port addressing the register being written in the same
// cycle. Without it, reads return stored contents only.
module param_register_file #(
    parameter int WIDTH    = 8,
    parameter int ADDR_W   = 3,
    parameter int ZERO_REG = 0
) (
    input  logic                  clk,
    input  logic                  res,
    param_register_file_if.slave  bus
);
    localparam int NUM_REGS = 1 << ADDR_W;
    localparam int LANES    = WIDTH / 8;

    logic                 wr_go;
    logic [WIDTH-1:0]     lane_mask;
    logic [WIDTH-1:0]     stored [NUM_REGS];
    logic [ADDR_W-1:0]    raddr  [2];
    logic [WIDTH-1:0]     rdata  [2];

    // Reset is handled in the flops, so only enable and request gate writes.
    // An all-zero wbe yields an all-zero mask, which leaves contents unchanged.
    assign wr_go = bus.en & bus.we;

    // Expand the byte-lane enables into a bit mask.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        assign lane_mask[8*gi +: 8] = {8{bus.wbe[gi]}};
    end

    // Storage: one register per address; register 0 has no flops when hardwired.
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
        if ((ZERO_REG != 0) && (gi == 0)) begin : g_zero
            assign stored[gi] = '0;
        end else begin : g_store
            logic [WIDTH-1:0] reg_q;
            logic [WIDTH-1:0] reg_d;

            // Next value: merge enabled lanes of wdata when this register is addressed.
            always_comb begin
                reg_d = reg_q;
                if (wr_go && (bus.waddr == ADDR_W'(gi))) begin
                    reg_d = (reg_q & ~lane_mask) | (bus.wdata & lane_mask);
                end
            end

            // State register; reset clears the register and overrides any write.
            always_ff @(posedge clk) begin
                if (!res) begin
                    reg_q <= '0;
                end else begin
                    reg_q <= reg_d;
                end
            end

            assign stored[gi] = reg_q;
        end
    end

    assign raddr[0] = bus.raddr_a;
    assign raddr[1] = bus.raddr_b;

`ifdef REGFILE_BYPASS_EN
    logic byp_go;
    // Forwarding is only meaningful when a write will actually commit this edge.
    assign byp_go = res & bus.en & bus.we;
`endif

    // Read ports share one lookup path so equal addresses always give equal data.
    for (genvar gi = 0; gi < 2; gi++) begin : g_rd
        // Combinational read with optional same-cycle forwarding and zero-register override.
        always_comb begin
            rdata[gi] = stored[raddr[gi]];
`ifdef REGFILE_BYPASS_EN
            if (byp_go && (raddr[gi] == bus.waddr)) begin
                rdata[gi] = (stored[raddr[gi]] & ~lane_mask) | (bus.wdata & lane_mask);
            end
`endif
            if ((ZERO_REG != 0) && (raddr[gi] == '0)) begin
                rdata[gi] = '0;
            end
        end
    end

    assign bus.rdata_a = rdata[0];
    assign bus.rdata_b = rdata[1];

endmodule
